// File: rtl/chu_spi_core_if.sv
// MMIO slot bus for one I/O core: select, strobes, register address and data.
// The master side is the mmio subsystem; the core sits on the slave side.
interface chu_spi_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] rd_data;
  logic [31:0] wr_data;

  modport master (output cs, output read, output write, output addr, output wr_data, input rd_data);
  modport slave  (input cs, input read, input write, input addr, input wr_data, output rd_data);
endinterface

// File: rtl/chu_spi_core.sv
// SPI master MMIO core: full-duplex 8-bit transfers, programmable SCLK divisor,
// software-driven active-low slave selects, received byte plus ready on read.
module chu_spi_core #(
  parameter int S = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  chu_spi_core_if.slave bus,
  output logic          o_spi_sclk,
  output logic          o_spi_mosi,
  input  logic          i_spi_miso,
  output logic [S-1:0]  o_spi_ss_n
);

  typedef enum logic [1:0] {IDLE = 2'd0, CPHA_DLY = 2'd1, P0 = 2'd2, P1 = 2'd3} state_t;

  state_t       r_state, w_state_next;
  logic [15:0]  r_c, r_dvsr;
  logic [2:0]   r_n;
  logic [7:0]   r_tx, r_rx_sh, r_rx;
  logic         r_cpol, r_cpha, r_sclk, r_mosi;
  logic [S-1:0] r_ss_n;
  logic [17:0]  r_ctrl;

  logic w_wr, w_start, w_h_done, w_ready, w_p, w_sclk_next;
  logic w_shift_rx, w_shift_tx, w_done;
  logic w_unused;

  assign w_wr     = bus.cs & bus.write;
  assign w_start  = w_wr & (bus.addr == 5'd2) & w_ready;
  assign w_h_done = (r_c == r_dvsr);
  assign w_unused = &{1'b0, bus.read, bus.wr_data[31:18]};

  assign bus.rd_data = {23'd0, w_ready, r_rx};
  assign o_spi_sclk  = r_sclk;
  assign o_spi_mosi  = r_mosi;
  assign o_spi_ss_n  = r_ss_n;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; every phase lasts dvsr+1 cycles.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_next = r_ctrl[17] ? CPHA_DLY : P0;
        else         w_state_next = IDLE;
      end
      CPHA_DLY: begin
        if (w_h_done) w_state_next = P0;
        else          w_state_next = CPHA_DLY;
      end
      P0: begin
        if (w_h_done) w_state_next = P1;
        else          w_state_next = P0;
      end
      P1: begin
        if (w_h_done) w_state_next = (r_n == 3'd7) ? IDLE : P0;
        else          w_state_next = P1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode: ready flag, datapath strobes and the next SCLK level.
  always_comb begin
    w_ready     = (r_state == IDLE);
    w_p         = ((r_state == P1) & ~r_cpha) | ((r_state == P0) & r_cpha);
    w_shift_rx  = (r_state == P0) & w_h_done;
    w_shift_tx  = (r_state == P1) & w_h_done & (r_n != 3'd7);
    w_done      = (r_state == P1) & w_h_done & (r_n == 3'd7);
    if (r_state == IDLE) w_sclk_next = r_ctrl[16];
    else                 w_sclk_next = r_cpol ? ~w_p : w_p;
  end

  // Software registers, shift registers and counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ss_n  <= '1;
      r_ctrl  <= 18'd0;
      r_c     <= 16'd0;
      r_dvsr  <= 16'd0;
      r_n     <= 3'd0;
      r_tx    <= 8'd0;
      r_rx_sh <= 8'd0;
      r_rx    <= 8'd0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      r_sclk <= w_sclk_next;
      if (w_wr && (bus.addr == 5'd1)) r_ss_n <= bus.wr_data[S-1:0];
      if (w_wr && (bus.addr == 5'd3)) r_ctrl <= bus.wr_data[17:0];
      // Timing parameters are frozen per transfer so ctrl writes only affect the next one.
      if (w_start) begin
        r_tx   <= bus.wr_data[7:0];
        r_n    <= 3'd0;
        r_c    <= 16'd0;
        r_dvsr <= r_ctrl[15:0];
        r_cpol <= r_ctrl[16];
        r_cpha <= r_ctrl[17];
      end else if (r_state != IDLE) begin
        r_mosi <= r_tx[7];
        r_c    <= w_h_done ? 16'd0 : r_c + 16'd1;
        if (w_shift_rx) r_rx_sh <= {r_rx_sh[6:0], i_spi_miso};
        if (w_shift_tx) begin
          r_tx <= {r_tx[6:0], 1'b0};
          r_n  <= r_n + 3'd1;
        end
        if (w_done) r_rx <= r_rx_sh;
      end
    end
  end

endmodule

// File: tb/tb_chu_spi_core.sv
// Directed bench for chu_spi_core: register access, SPI modes, busy/ctrl writes, reset abort.
module tb_chu_spi_core;
  logic       clk = 1'b0;
  logic       reset;
  logic       sclk, mosi, miso;
  logic [3:0] ss_n;
  logic       loopback;
  logic [7:0] slave_byte;
  int         fall_cnt = 0;
  int         fall_base;
  int         idx;
  logic       slave_bit;
  int         n_checks = 0;
  int         n_fail = 0;
  int         busy, rises, lowc;
  logic [7:0] mb;

  chu_spi_core_if bus();

  chu_spi_core #(.S(4)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .bus        (bus),
    .o_spi_sclk (sclk),
    .o_spi_mosi (mosi),
    .i_spi_miso (miso),
    .o_spi_ss_n (ss_n)
  );

  always #5 clk = ~clk;

  // Slave model: presents byte MSB first, advancing one bit after each SCLK falling edge.
  always @(negedge sclk) begin
    #1 fall_cnt = fall_cnt + 1;
  end

  always_comb begin
    idx = fall_cnt - fall_base;
    slave_bit = (idx >= 0 && idx < 8) ? slave_byte[3'(7 - idx)] : 1'b0;
  end

  assign miso = loopback ? mosi : slave_bit;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = 5'd0; bus.wr_data = 32'd0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    idle_bus();
  endtask

  // Start a transfer and watch it to completion; optionally issue one extra write at busy cycle 'mid'.
  task automatic xfer(input logic [7:0] tx, input int mid, input logic [4:0] ma, input logic [31:0] md,
                      output int o_busy, output int o_rises, output logic [7:0] o_mb);
    logic prev;
    int   k;
    o_busy = 0; o_rises = 0; o_mb = 8'd0;
    prev = sclk;
    wr(5'd2, {24'd0, tx});
    k = 0;
    while (bus.rd_data[8] == 1'b0 && k < 4000) begin
      o_busy++;
      if (sclk && !prev) begin o_rises++; o_mb = {o_mb[6:0], mosi}; end
      prev = sclk;
      if (k == mid) begin
        bus.cs = 1'b1; bus.write = 1'b1; bus.addr = ma; bus.wr_data = md;
      end else begin
        idle_bus();
      end
      @(negedge clk);
      k++;
    end
    idle_bus();
    if (sclk && !prev) begin o_rises++; o_mb = {o_mb[6:0], mosi}; end
    chk("xfer_timeout", (k >= 4000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic count_low(input int cycles, output int o_low);
    o_low = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.rd_data[8] == 1'b0) o_low++;
    end
  endtask

  initial begin
    idle_bus();
    loopback = 1'b1;
    slave_byte = 8'h00;
    fall_base = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1. reset state, ignored address, reset beating a write
    chk("rst_rd_data", bus.rd_data, 32'h100);
    chk("rst_ss_n", 32'(ss_n), 32'hF);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    wr(5'd0, 32'hA5);
    count_low(4, lowc);
    chk("addr0_ignored", 32'(lowc), 32'd0);
    wr(5'd1, 32'h5);
    chk("ss_write", 32'(ss_n), 32'h5);
    @(negedge clk);
    reset = 1'b1;
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 5'd1; bus.wr_data = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    idle_bus();
    chk("reset_wins_ss", 32'(ss_n), 32'hF);

    // 2. mode 0, dvsr=1, loopback
    wr(5'd3, 32'h1);
    xfer(8'hA5, -1, 5'd0, 32'd0, busy, rises, mb);
    chk("m0_busy", 32'(busy), 32'd32);
    chk("m0_rises", 32'(rises), 32'd8);
    chk("m0_mosi", 32'(mb), 32'hA5);
    chk("m0_rd_data", bus.rd_data, 32'h1A5);

    // 3. mode 3, dvsr=0, slave returns 0x3C
    wr(5'd3, 32'h30000);
    @(negedge clk);
    chk("m3_sclk_idle", 32'(sclk), 32'd1);
    loopback = 1'b0;
    slave_byte = 8'h3C;
    fall_base = fall_cnt;
    xfer(8'h00, -1, 5'd0, 32'd0, busy, rises, mb);
    chk("m3_busy", 32'(busy), 32'd17);
    chk("m3_rd_data", bus.rd_data, 32'h13C);
    chk("m3_sclk_after", 32'(sclk), 32'd1);
    loopback = 1'b1;

    // 4. busy write ignored; start write on the return-to-idle cycle ignored
    wr(5'd3, 32'h1);
    xfer(8'h11, 6, 5'd2, 32'hFF, busy, rises, mb);
    chk("busy_mosi", 32'(mb), 32'h11);
    chk("busy_len", 32'(busy), 32'd32);
    chk("busy_rd_data", bus.rd_data, 32'h111);
    count_low(12, lowc);
    chk("busy_no_extra", 32'(lowc), 32'd0);
    xfer(8'h33, 31, 5'd2, 32'h77, busy, rises, mb);
    chk("edge_len", 32'(busy), 32'd32);
    count_low(12, lowc);
    chk("edge_no_extra", 32'(lowc), 32'd0);
    chk("edge_rd_data", bus.rd_data, 32'h133);

    // 5. ctrl change mid-transfer affects only the next transfer
    wr(5'd3, 32'h3);
    xfer(8'h5A, 5, 5'd3, 32'h0, busy, rises, mb);
    chk("ctrl_cur_busy", 32'(busy), 32'd64);
    chk("ctrl_cur_rd", bus.rd_data, 32'h15A);
    xfer(8'h96, -1, 5'd0, 32'd0, busy, rises, mb);
    chk("ctrl_next_busy", 32'(busy), 32'd16);

    // 6. reset at cycle 10 of a transfer
    wr(5'd3, 32'h1);
    wr(5'd1, 32'h0);
    chk("ss_low", 32'(ss_n), 32'h0);
    wr(5'd2, 32'hFF);
    repeat (9) @(negedge clk);
    chk("mid_busy", 32'(bus.rd_data[8]), 32'd0);
    chk("mid_mosi", 32'(mosi), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_mosi", 32'(mosi), 32'd0);
    chk("abort_ss_n", 32'(ss_n), 32'hF);
    chk("abort_rd_data", bus.rd_data, 32'h100);
    wr(5'd3, 32'h1);
    xfer(8'hC3, -1, 5'd0, 32'd0, busy, rises, mb);
    chk("after_busy", 32'(busy), 32'd32);
    chk("after_rd_data", bus.rd_data, 32'h1C3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
